dm_store_buffer: RTL and testbench
==================================

// Module: dm_store_buffer
// PURPOSE
// - Store buffer directly upstream of the data memory: accepts stores from the MEM stage and retires them to DM.
//   At most one store retires per cycle.
// - DM has one word address port and a whole-word write enable. Byte/half stores are therefore done by read-merge-write
//   in a single cycle, using DM's combinational read data.
// - Loads own the DM port with priority. Load data is DM data overlaid with any matching buffered bytes.
// PARAMETERS
// - DEPTH   4   number of entries; power of 2, >=2
// - ADDR_W  32  byte address width
// PORTS
// - Clk        in   1       clock, rising edge
// - reset      in   1       asynchronous, active-low reset
// - st_valid   in   1       store request
// - st_ready   out  1       buffer can accept a store
// - st_addr    in   ADDR_W  store byte address; [1:0] ignored
// - st_data    in   32      store data, already lane-aligned
// - st_be      in   4       byte enables; bit i = byte lane i
// - ld_valid   in   1       load uses DM port this cycle
// - ld_addr    in   ADDR_W  load byte address
// - ld_data    out  32      forwarded load word
// - empty      out  1       no buffered stores
// - dm_we      out  1       to DM WE
// - dm_addr    out  32      to DM addr
// - dm_wd      out  32      to DM WD
// - dm_rd      in   32      from DM D (combinational read of dm_addr)
// BEHAVIOUR
// - Circular FIFO of {word addr, data, be}, with head/tail pointers that wrap modulo DEPTH and count 0..DEPTH.
// - Reset (reset==0, async) forces: count=0, head=tail=0.
//   - Consequences: st_ready=1, empty=1, dm_we=0, and ld_data=dm_rd.
//   - Entry contents are don't-care after reset.
//   - A drain in progress is abandoned; no write occurs while reset is low.
// - st_ready = (count != DEPTH). There is no same-cycle full bypass.
// - Push on posedge when st_valid && st_ready.
//   - st_be==0: the store is accepted but allocates nothing.
// - Port mux:
//   - ld_valid=1: dm_addr = {ld_addr[31:2],2'b00}, dm_we=0, no drain.
//   - ld_valid=0 and count>0: dm_addr = head word address and dm_we=1.
//     - dm_wd = per byte, head.be[i] ? head.data byte i : dm_rd byte i.
//     - The head pops on posedge.
//   - ld_valid=0 and count==0: dm_addr = {ld_addr[31:2],2'b00}, dm_we=0.
// - Minimum latency is 1 cycle: an entry pushed at edge N drains no earlier than the cycle after edge N.
// - Push and pop in the same cycle: count is unchanged and both pointers advance.
// - Forwarding: ld_data starts from dm_rd.
//   - Valid entries whose word address matches ld_addr[31:2] are applied oldest to newest, so the newest enabled byte wins.
//   - A store being pushed in the same cycle is NOT forwarded.
// - empty = (count==0). It is used by the control logic for halt and drain-before-syscall.
// - Program order is preserved: stores retire strictly in FIFO order.
// CONFIGURATION
// - Macro STB_COALESCE_EN.
// - Defined:
//   - Condition: a pushed store matches the newest valid entry's word address, that entry is not the head being drained
//     this cycle, and count>0.
//   - Action: the store merges into that entry (data bytes overwritten where st_be set; be |= st_be). No allocation;
//     count unchanged.
//   - When the merge happens, st_ready remains 1 even if count==DEPTH.
// - Undefined: every store with st_be!=0 allocates a new entry.
// TESTING
// - T1: reset low then high; push addr 0x10, data 0x11223344, be F, ld_valid=0.
//   Next cycle: dm_we=1, dm_addr=0x10, dm_wd=0x11223344. Following cycle: empty=1.
// - T2: push addr 0x14, data 0x0000AB00, be 0010; dm_rd=0xFFFFFFFF -> drain cycle dm_wd=0xFFFFABFF.
// - T3: hold ld_valid=1; push 4 stores to 0x40..0x4C.
//   After 4th: st_ready=0 and a 5th request is held. Drop ld_valid: dm_we=1 for 4 consecutive cycles,
//   addrs 0x40,0x44,0x48,0x4C in order.
// - T4: buffered entry addr 0x20, data 0x0000BEEF, be 0011; ld_valid=1, ld_addr=0x22, dm_rd=0x12345678 -> ld_data=0x1234BEEF.
//   Add newer entry addr 0x20, data 0x000000AA, be 0001 -> ld_data=0x1234BEAA.
// - T5: count=3 with drain active; pull reset low mid-cycle -> dm_we=0, empty=1, st_ready=1 immediately.
//   After release: no DM writes.
// - T6: ld_valid=1; push addr 0x30, be 0001, data 0x01, then addr 0x30, be 0010, data 0x0200.
//   count=1 with STB_COALESCE_EN, 2 without. Either way the final DM word at 0x30 has bytes [15:0]=0x0201.

Source files
------------

// File: rtl/dm_store_buffer.sv
// Store buffer between the MEM stage and the single-ported data memory, with load forwarding.
// Optional store coalescing into the newest entry is enabled by defining STB_COALESCE_EN.
module dm_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [3:0]        st_be,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [31:0]       ld_data,
  output logic              empty,
  output logic              dm_we,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wd,
  input  logic [31:0]       dm_rd
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned WordW = ADDR_W - 2;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0] CntOne = (PtrW+1)'(1);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(DEPTH);

  logic [WordW-1:0] addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];

  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;

  logic [WordW-1:0]  st_word, ld_word;
  logic [PtrW-1:0]   newest, idx;
  logic [ADDR_W-1:0] port_addr;
  logic              full, drain, merge, alloc, coal_ok;

  always_comb begin
    st_word = st_addr[ADDR_W-1:2];
    ld_word = ld_addr[ADDR_W-1:2];
    newest  = tail_q - PtrOne;
    empty   = (count_q == '0);
    full    = (count_q == CntFull);
    drain   = !ld_valid && !empty;
`ifdef STB_COALESCE_EN
    // A single entry being drained this cycle is no longer a merge target.
    coal_ok  = !empty && (addr_q[newest] == st_word) && !(drain && count_q == CntOne);
    st_ready = !full || coal_ok;
    merge    = st_valid && (st_be != 4'b0000) && coal_ok;
`else
    coal_ok  = 1'b0;
    st_ready = !full;
    merge    = 1'b0;
`endif
    alloc = st_valid && st_ready && (st_be != 4'b0000) && !merge;
  end

  // DM port: loads have priority, otherwise retire the head with read-merge-write.
  always_comb begin
    dm_we     = drain;
    port_addr = drain ? {addr_q[head_q], 2'b00} : {ld_word, 2'b00};
    dm_addr   = 32'(port_addr);
    dm_wd     = dm_rd;
    for (int b = 0; b < 4; b++) begin
      if (be_q[head_q][b]) dm_wd[8*b +: 8] = data_q[head_q][8*b +: 8];
    end
  end

  // Oldest to newest so the youngest matching byte wins.
  always_comb begin
    ld_data = dm_rd;
    idx     = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (((PtrW+1)'(i) < count_q) && (addr_q[idx] == ld_word)) begin
        for (int b = 0; b < 4; b++) begin
          if (be_q[idx][b]) ld_data[8*b +: 8] = data_q[idx][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc) tail_q <= tail_q + PtrOne;
      if (drain) head_q <= head_q + PtrOne;
      if (alloc && !drain)      count_q <= count_q + CntOne;
      else if (!alloc && drain) count_q <= count_q - CntOne;
    end
  end

  // Entry payload needs no reset; validity is tracked by the pointers.
  always_ff @(posedge Clk) begin
    if (alloc) begin
      addr_q[tail_q] <= st_word;
      data_q[tail_q] <= st_data;
      be_q[tail_q]   <= st_be;
    end
`ifdef STB_COALESCE_EN
    if (merge) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) data_q[newest][8*b +: 8] <= st_data[8*b +: 8];
      end
      be_q[newest] <= be_q[newest] | st_be;
    end
`endif
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: expected DM writes and forwarded loads are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_dm_store_buffer;

  logic        Clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        empty;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] ld_q[$];
  logic        ld_check;
  int          tests = 0;
  int          fails = 0;

  logic [31:0] mem [64];
  logic        preset_en;
  logic [5:0]  preset_idx;
  logic [31:0] preset_val;

  always #5 Clk = ~Clk;

  dm_store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .empty    (empty),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .dm_rd    (dm_rd)
  );

  // Data memory model: combinational read, write on rising edge.
  assign dm_rd = mem[dm_addr[7:2]];
  always @(posedge Clk) begin
    if (dm_we) mem[dm_addr[7:2]] <= dm_wd;
    else if (preset_en) mem[preset_idx] <= preset_val;
  end

  always @(negedge Clk) begin
    if (dm_we) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%h wd=%h, required no write", dm_addr, dm_wd);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (dm_addr !== e.addr || dm_wd !== e.data) begin
          fails++;
          $display("FAIL dm_write: got addr=%h wd=%h, required addr=%h wd=%h",
                   dm_addr, dm_wd, e.addr, e.data);
        end
      end
    end
    if (ld_check) begin
      tests++;
      if (ld_q.size() == 0) begin
        fails++;
        $display("FAIL ld_data: got %h, required (no expectation queued)", ld_data);
      end else begin
        logic [31:0] exp;
        exp = ld_q.pop_front();
        if (ld_data !== exp) begin
          fails++;
          $display("FAIL ld_data: got %h, required %h", ld_data, exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    n = 0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    while (!st_ready && n < 50) begin
      step();
      n++;
    end
    if (!st_ready) check("push_ready_timeout", {31'b0, st_ready}, 32'd1);
    step();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (!empty && n < 50) begin
      step();
      n++;
    end
    check(name, {31'b0, empty}, 32'd1);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  initial begin
    reset      = 1'b0;
    st_valid   = 1'b0;
    st_addr    = '0;
    st_data    = '0;
    st_be      = '0;
    ld_valid   = 1'b0;
    ld_addr    = 32'h100;
    ld_check   = 1'b0;
    preset_en  = 1'b0;
    preset_idx = '0;
    preset_val = '0;
    #1;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_ready", {31'b0, st_ready}, 32'd1);
    check("rst_dm_we", {31'b0, dm_we}, 32'd0);

    // Preload DM words while reset holds the buffer idle.
    preset_en = 1'b1;
    preset_idx = 6'd5;  preset_val = 32'hFFFF_FFFF; step();
    preset_idx = 6'd8;  preset_val = 32'h1234_5678; step();
    preset_idx = 6'd12; preset_val = 32'hDEAD_BEEF; step();
    preset_en = 1'b0;
    reset = 1'b1;
    step();

    // T1: full-word store drains the next cycle
    expect_wr(32'h10, 32'h1122_3344);
    push(32'h10, 32'h1122_3344, 4'hF);
    step();
    check("t1_empty", {31'b0, empty}, 32'd1);

    // T2: byte store merges with DM read data
    expect_wr(32'h14, 32'hFFFF_ABFF);
    push(32'h14, 32'h0000_AB00, 4'b0010);
    step();
    check("t2_empty", {31'b0, empty}, 32'd1);

    // T3: fill behind a load, then drain in order
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h40 + 32'(4*i), 32'hA0 + 32'(i), 4'hF);
    check("t3_full_ready", {31'b0, st_ready}, 32'd0);
    st_valid = 1'b1; st_addr = 32'h50; st_data = 32'hA4; st_be = 4'hF;
    step();
    step();
    check("t3_held_ready", {31'b0, st_ready}, 32'd0);
    for (int i = 0; i < 5; i++) expect_wr(32'h40 + 32'(4*i), 32'hA0 + 32'(i));
    ld_valid = 1'b0;
    push(32'h50, 32'hA4, 4'hF);
    wait_empty("t3_empty");

    // T4: forwarding, newest byte wins; same-cycle push is not forwarded
    ld_valid = 1'b1;
    ld_addr  = 32'h22;
    push(32'h20, 32'h0000_BEEF, 4'b0011);
    ld_check = 1'b1;
    ld_q.push_back(32'h1234_BEEF);
    push(32'h20, 32'h0000_00AA, 4'b0001);
    ld_q.push_back(32'h1234_BEAA);
    step();
    ld_check = 1'b0;
`ifdef STB_COALESCE_EN
    expect_wr(32'h20, 32'h1234_BEAA);
`else
    expect_wr(32'h20, 32'h1234_BEEF);
    expect_wr(32'h20, 32'h1234_BEAA);
`endif
    ld_valid = 1'b0;
    ld_addr  = 32'h100;
    wait_empty("t4_empty");

    // T5: async reset during a drain abandons every buffered store
    ld_valid = 1'b1;
    push(32'h60, 32'h6, 4'hF);
    push(32'h64, 32'h7, 4'hF);
    push(32'h68, 32'h8, 4'hF);
    ld_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("t5_dm_we", {31'b0, dm_we}, 32'd0);
    check("t5_empty", {31'b0, empty}, 32'd1);
    check("t5_ready", {31'b0, st_ready}, 32'd1);
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("t5_still_empty", {31'b0, empty}, 32'd1);

    // T6: two partial stores to one word
    ld_valid = 1'b1;
    push(32'h30, 32'h0000_0001, 4'b0001);
    push(32'h30, 32'h0000_0200, 4'b0010);
`ifdef STB_COALESCE_EN
    expect_wr(32'h30, 32'hDEAD_0201);
`else
    expect_wr(32'h30, 32'hDEAD_BE01);
    expect_wr(32'h30, 32'hDEAD_0201);
`endif
    ld_valid = 1'b0;
    wait_empty("t6_empty");
    step();
    check("t6_mem_low", {16'h0, mem[12][15:0]}, 32'h0000_0201);
    check("t6_mem_word", mem[12], 32'hDEAD_0201);

    check("wr_q_drained", wr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
